// File: rtl/mandelbrot_pixel_packer.sv
// mandelbrot_pixel_packer: packs 4-bit pixel pairs into bytes through a first-word-fall-through FIFO.
// Define MANDELBROT_PACKER_CHECKSUM_EN to add an 8-bit XOR checksum of the bytes popped per frame.
module mandelbrot_pixel_packer #(
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 240,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       new_ctr,
  input  logic [3:0] ctr_in,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_sof,
  output logic       out_eol,
  output logic       overflow,
  output logic       frame_done,
  output logic       busy
`ifdef MANDELBROT_PACKER_CHECKSUM_EN
  ,
  output logic [7:0] checksum
`endif
);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = HEIGHT > 1 ? $clog2(HEIGHT) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;
  state_t state, state_nx;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [3:0] nib;
  logic [9:0] mem [FIFO_DEPTH];
  logic [AW:0] wr, rd;
  logic [9:0] head;
  logic empty, full, strobe, push, pop, wr_en, drop, x_last, y_last, sof;
  assign empty  = wr == rd;
  assign full   = wr[AW] != rd[AW] && wr[AW-1:0] == rd[AW-1:0];
  assign strobe = state == COLLECT && new_ctr && !frame_start;
  assign x_last = x == XW'(WIDTH - 1);
  assign y_last = y == YW'(HEIGHT - 1);
  assign sof    = x == XW'(1) && y == '0;
  assign push   = strobe && x[0];
  assign pop    = out_valid && out_ready;
  assign wr_en  = push && (!full || pop);
  assign drop   = push && full && !pop;
  assign head   = empty ? '0 : mem[rd[AW-1:0]];
  assign out_valid  = !empty;
  assign out_data   = head[7:0];
  assign out_sof    = head[8];
  assign out_eol    = head[9];
  assign busy       = state != IDLE;
  assign frame_done = state == DRAIN && empty && !frame_start && !reset;
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nx;
  always_comb
    state_nx = frame_start ? COLLECT :
               (strobe && x_last && y_last) ? DRAIN :
               frame_done ? IDLE : state;
  always_ff @(posedge clk)
    if (wr_en) mem[wr[AW-1:0]] <= {x_last, sof, ctr_in, nib};
  always_ff @(posedge clk) begin
    if (reset || frame_start) begin
      x        <= '0;
      y        <= '0;
      nib      <= '0;
      wr       <= '0;
      rd       <= '0;
      overflow <= 1'b0;
    end else begin
      if (strobe) begin
        x <= x_last ? '0 : x + 1'b1;
        if (x_last) y <= y_last ? '0 : y + 1'b1;
        if (!x[0]) nib <= ctr_in;
      end
      if (wr_en) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
      if (drop) overflow <= 1'b1;
    end
  end
`ifdef MANDELBROT_PACKER_CHECKSUM_EN
  // Nothing pops once the frame has drained, so the value naturally freezes in IDLE.
  always_ff @(posedge clk)
    if (reset || frame_start) checksum <= '0;
    else if (pop) checksum <= checksum ^ out_data;
`endif
endmodule

// File: tb/tb_mandelbrot_pixel_packer.sv
// tb_mandelbrot_pixel_packer: directed and random stimulus checked against a queue-based frame model.
module tb_mandelbrot_pixel_packer;
  localparam int W = 4, H = 2, D = 2;
  logic clk = 0, reset, frame_start, new_ctr, out_ready;
  logic [3:0] ctr_in;
  logic [7:0] out_data;
  logic out_valid, out_sof, out_eol, overflow, frame_done, busy;
`ifdef MANDELBROT_PACKER_CHECKSUM_EN
  logic [7:0] checksum;
`endif
  int compared = 0, mismatched = 0, done_cnt = 0;
  always #5 clk = ~clk;
  mandelbrot_pixel_packer #(.WIDTH(W), .HEIGHT(H), .FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .new_ctr(new_ctr), .ctr_in(ctr_in),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof),
    .out_eol(out_eol), .overflow(overflow), .frame_done(frame_done), .busy(busy)
`ifdef MANDELBROT_PACKER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );
  typedef enum {M_IDLE, M_COLLECT, M_DRAIN} mstate_t;
  mstate_t ms = M_IDLE;
  logic [9:0] q[$];
  logic [7:0] got[$];
  int p = 0;
  logic [3:0] lat = 0;
  logic m_ovf = 0;
  logic [7:0] m_cs = 0;
  bit started = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic bit exp_done();
    return ms == M_DRAIN && q.size() == 0 && !frame_start && !reset;
  endfunction
  task automatic check();
    if (!started) return;
    chk("valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
    if (q.size() != 0) begin
      chk("data", {24'd0, out_data}, {24'd0, q[0][7:0]});
      chk("sof", {31'd0, out_sof}, {31'd0, q[0][8]});
      chk("eol", {31'd0, out_eol}, {31'd0, q[0][9]});
    end
    chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    chk("busy", {31'd0, busy}, {31'd0, ms != M_IDLE});
    chk("frame_done", {31'd0, frame_done}, {31'd0, exp_done()});
`ifdef MANDELBROT_PACKER_CHECKSUM_EN
    if (exp_done()) chk("checksum", {24'd0, checksum}, {24'd0, m_cs});
`endif
    if (frame_done) done_cnt++;
    if (out_valid && out_ready && !reset && !frame_start) got.push_back(out_data);
  endtask
  // Frame-level model: pixel index p runs over the frame, bytes live in a bounded queue.
  task automatic model_step();
    bit fd, pop, full;
    fd   = exp_done();
    pop  = q.size() != 0 && out_ready;
    full = q.size() == D;
    if (reset) begin
      q.delete(); ms = M_IDLE; p = 0; m_ovf = 0; m_cs = 0;
    end else if (frame_start) begin
      q.delete(); ms = M_COLLECT; p = 0; m_ovf = 0; m_cs = 0;
    end else begin
      if (pop) begin
        m_cs ^= q[0][7:0];
        void'(q.pop_front());
      end
      if (ms == M_COLLECT && new_ctr) begin
        if (p % 2 == 0) lat = ctr_in;
        else if (!full || pop) q.push_back({p % W == W - 1, p == 1, ctr_in, lat});
        else m_ovf = 1;
        p++;
        if (p == W * H) begin
          p = 0;
          ms = M_DRAIN;
        end
      end else if (fd) ms = M_IDLE;
    end
  endtask
  task automatic step(input logic r, input logic fs, input logic nc, input logic [3:0] ci, input logic rdy);
    reset = r; frame_start = fs; new_ctr = nc; ctr_in = ci; out_ready = rdy;
    #1;
    check();
    @(posedge clk);
    model_step();
    started = 1;
    @(negedge clk);
  endtask
  initial begin
    logic [7:0] exp_a[4] = '{8'h21, 8'h43, 8'h65, 8'h87};
    logic [7:0] exp_d[4] = '{8'hEF, 8'hCD, 8'hAB, 8'h89};
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_data", {24'd0, out_data}, 0);
    chk("rst_sof", {31'd0, out_sof}, 0);
    chk("rst_eol", {31'd0, out_eol}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_frame_done", {31'd0, frame_done}, 0);
    chk("rst_overflow", {31'd0, overflow}, 0);
    // Basic frame, consumer always ready.
    step(0, 0, 1, 4'h9, 1);
    got.delete(); done_cnt = 0;
    step(0, 1, 0, 0, 1);
    for (int i = 1; i <= 8; i++) step(0, 0, 1, 4'(i), 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);
    chk("a_count", got.size(), 4);
    for (int i = 0; i < 4; i++) chk("a_byte", {24'd0, got[i]}, {24'd0, exp_a[i]});
    chk("a_done", done_cnt, 1);
    chk("a_overflow", {31'd0, overflow}, 0);
`ifdef MANDELBROT_PACKER_CHECKSUM_EN
    chk("a_checksum", {24'd0, checksum}, 32'h80);
`endif
    // Consumer stalled for the whole frame: two bytes held, the rest dropped.
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 4'(9 + i), 0);
    chk("b_overflow", {31'd0, overflow}, 1);
    chk("b_busy", {31'd0, busy}, 1);
    chk("b_head", {24'd0, out_data}, 32'hA9);
    got.delete(); done_cnt = 0;
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);
    chk("b_count", got.size(), 2);
    chk("b_byte1", {24'd0, got[1]}, 32'hCB);
    chk("b_done", done_cnt, 1);
    // Full FIFO with a simultaneous pop on the push cycle.
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 4'(i), 0);
    step(0, 0, 1, 4'h5, 1);
    chk("c_overflow", {31'd0, overflow}, 0);
    step(0, 0, 1, 4'h6, 1);
    step(0, 0, 1, 4'h7, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);
    chk("c_overflow_end", {31'd0, overflow}, 0);
    // Abort after three strobes; the restarting frame_start also carries a strobe.
    done_cnt = 0;
    step(0, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 4'(3 + i), 1);
    step(0, 1, 1, 4'h1, 1);
    chk("d_flushed", {31'd0, out_valid}, 0);
    got.delete();
    for (int i = 0; i < 8; i++) step(0, 0, 1, 4'(15 - i), 1);
    step(0, 0, 0, 0, 1);
    chk("d_count", got.size(), 4);
    for (int i = 0; i < 4; i++) chk("d_byte", {24'd0, got[i]}, {24'd0, exp_d[i]});
    // frame_start lands on the drain-empty cycle: restart instead of frame_done.
    step(0, 1, 0, 0, 1);
    chk("d_done", done_cnt, 0);
    chk("d_busy", {31'd0, busy}, 1);
    // Reset while draining with two bytes buffered.
    for (int i = 0; i < 8; i++) step(0, 0, 1, 4'(i), 0);
    chk("e_buffered", {31'd0, out_valid}, 1);
    step(1, 0, 0, 0, 0);
    chk("e_valid", {31'd0, out_valid}, 0);
    chk("e_busy", {31'd0, busy}, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    chk("e_done", done_cnt, 0);
    // Random traffic.
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 149) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0,
           4'($urandom), 1'($urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
